// File: rtl/frame_sequencer.sv
// Serial frame sequencer: LSB-first length header, payload byte assembly, gap timeout.
// Define FRAME_SEQ_CRC_EN to receive and check a 16-bit CRC-16-CCITT trailer after the payload.
module frame_sequencer #(
    parameter int unsigned MAX_LEN = 64,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       demod_bit,
    input  logic       demod_valid,
    output logic       fsc_end,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       frame_done,
    output logic       frame_err,
    output logic       busy
);
    localparam int unsigned GAP_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HDR     = 3'd1,
        S_PAYLOAD = 3'd2,
        S_CRC     = 3'd3,
        S_END     = 3'd4
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [7:0]       r_len, w_len_nxt;
    logic [7:0]       r_shift, w_shift_nxt;
    logic [3:0]       r_bit_cnt, w_bit_cnt_nxt;
    logic [7:0]       r_byte_cnt, w_byte_cnt_nxt;
    logic [GAP_W-1:0] r_gap, w_gap_nxt;
    logic             r_armed, w_armed_nxt;
    logic             r_fsc_end, w_fsc_end_nxt;
    logic [7:0]       r_byte_out, w_byte_out_nxt;
    logic             r_byte_valid, w_byte_valid_nxt;
    logic             r_frame_done, w_frame_done_nxt;
    logic             r_frame_err, w_frame_err_nxt;
    logic             r_busy, w_busy_nxt;
    logic [7:0]       w_shift_in;
    logic             w_in_frame;
    logic             w_gap_hit;
`ifdef FRAME_SEQ_CRC_EN
    logic [15:0]      r_crc, w_crc_nxt;
    logic [15:0]      r_crc_rx, w_crc_rx_nxt;
    logic [15:0]      w_crc_upd;
    logic [15:0]      w_crc_rx_in;
    logic             w_crc_fb;

    // Bitwise CRC-16-CCITT (poly 0x1021), bits taken in arrival order
    assign w_crc_fb    = r_crc[15] ^ demod_bit;
    assign w_crc_upd   = {r_crc[14:0], 1'b0} ^ (w_crc_fb ? 16'h1021 : 16'h0000);
    assign w_crc_rx_in = {demod_bit, r_crc_rx[15:1]};
`endif

    assign w_shift_in = {demod_bit, r_shift[7:1]};
    assign w_in_frame = (r_state == S_HDR) || (r_state == S_PAYLOAD) || (r_state == S_CRC);
    assign w_gap_hit  = (r_gap == GAP_W'(TIMEOUT - 1));

    always_comb begin
        w_state_nxt      = r_state;
        w_len_nxt        = r_len;
        w_shift_nxt      = r_shift;
        w_bit_cnt_nxt    = r_bit_cnt;
        w_byte_cnt_nxt   = r_byte_cnt;
        w_gap_nxt        = r_gap;
        w_armed_nxt      = r_armed;
        w_byte_out_nxt   = r_byte_out;
        w_fsc_end_nxt    = 1'b0;
        w_byte_valid_nxt = 1'b0;
        w_frame_done_nxt = 1'b0;
        w_frame_err_nxt  = 1'b0;
`ifdef FRAME_SEQ_CRC_EN
        w_crc_nxt        = r_crc;
        w_crc_rx_nxt     = r_crc_rx;
`endif

        // Gap watchdog; completion needs demod_valid=1 so it can never collide with a timeout
        if (w_in_frame) begin
            if (demod_valid) begin
                w_gap_nxt = '0;
            end else if (w_gap_hit) begin
                w_gap_nxt       = '0;
                w_frame_err_nxt = 1'b1;
                w_state_nxt     = S_END;
            end else begin
                w_gap_nxt = r_gap + GAP_W'(1);
            end
        end

        case (r_state)
            S_IDLE: begin
                if (!demod_valid) begin
                    w_armed_nxt = 1'b1;
                end else if (r_armed) begin
                    w_state_nxt    = S_HDR;
                    w_shift_nxt    = w_shift_in;
                    w_bit_cnt_nxt  = 4'd1;
                    w_byte_cnt_nxt = 8'd0;
                    w_gap_nxt      = '0;
`ifdef FRAME_SEQ_CRC_EN
                    w_crc_nxt      = 16'hFFFF;
`endif
                end
            end
            S_HDR: begin
                if (demod_valid) begin
                    w_shift_nxt   = w_shift_in;
                    w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    if (r_bit_cnt == 4'd7) begin
                        w_len_nxt     = w_shift_in;
                        w_bit_cnt_nxt = 4'd0;
                        if ((w_shift_in == 8'd0) || (w_shift_in > 8'(MAX_LEN))) begin
                            w_frame_err_nxt = 1'b1;
                            w_state_nxt     = S_END;
                        end else begin
                            w_state_nxt = S_PAYLOAD;
                        end
                    end
                end
            end
            S_PAYLOAD: begin
                if (demod_valid) begin
                    w_shift_nxt   = w_shift_in;
                    w_bit_cnt_nxt = r_bit_cnt + 4'd1;
`ifdef FRAME_SEQ_CRC_EN
                    w_crc_nxt     = w_crc_upd;
`endif
                    if (r_bit_cnt[2:0] == 3'd7) begin
                        w_bit_cnt_nxt    = 4'd0;
                        w_byte_out_nxt   = w_shift_in;
                        w_byte_valid_nxt = 1'b1;
                        w_byte_cnt_nxt   = r_byte_cnt + 8'd1;
                        if ((r_byte_cnt + 8'd1) == r_len) begin
`ifdef FRAME_SEQ_CRC_EN
                            w_state_nxt      = S_CRC;
`else
                            w_frame_done_nxt = 1'b1;
                            w_state_nxt      = S_END;
`endif
                        end
                    end
                end
            end
`ifdef FRAME_SEQ_CRC_EN
            S_CRC: begin
                if (demod_valid) begin
                    w_crc_rx_nxt  = w_crc_rx_in;
                    w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    if (r_bit_cnt == 4'd15) begin
                        w_bit_cnt_nxt    = 4'd0;
                        w_frame_done_nxt = (w_crc_rx_in == r_crc);
                        w_frame_err_nxt  = (w_crc_rx_in != r_crc);
                        w_state_nxt      = S_END;
                    end
                end
            end
`endif
            S_END: begin
                w_fsc_end_nxt = 1'b1;
                w_armed_nxt   = 1'b0;
                w_gap_nxt     = '0;
                w_state_nxt   = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_len        <= 8'd0;
            r_shift      <= 8'd0;
            r_bit_cnt    <= 4'd0;
            r_byte_cnt   <= 8'd0;
            r_gap        <= '0;
            r_armed      <= 1'b1;
            r_fsc_end    <= 1'b0;
            r_byte_out   <= 8'h00;
            r_byte_valid <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            r_busy       <= 1'b0;
`ifdef FRAME_SEQ_CRC_EN
            r_crc        <= 16'h0000;
            r_crc_rx     <= 16'h0000;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_len        <= w_len_nxt;
            r_shift      <= w_shift_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_byte_cnt   <= w_byte_cnt_nxt;
            r_gap        <= w_gap_nxt;
            r_armed      <= w_armed_nxt;
            r_fsc_end    <= w_fsc_end_nxt;
            r_byte_out   <= w_byte_out_nxt;
            r_byte_valid <= w_byte_valid_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_frame_err  <= w_frame_err_nxt;
            r_busy       <= w_busy_nxt;
`ifdef FRAME_SEQ_CRC_EN
            r_crc        <= w_crc_nxt;
            r_crc_rx     <= w_crc_rx_nxt;
`endif
        end
    end

    assign fsc_end    = r_fsc_end;
    assign byte_out   = r_byte_out;
    assign byte_valid = r_byte_valid;
    assign frame_done = r_frame_done;
    assign frame_err  = r_frame_err;
    assign busy       = r_busy;

endmodule

// File: tb/tb_frame_sequencer.sv
// Self-checking bench for frame_sequencer: table of frames plus hand-written reset and CRC sequences.
module tb_frame_sequencer;
    localparam int MAX_LEN = 64;
    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       demod_bit;
    logic       demod_valid;
    logic       fsc_end;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       frame_done;
    logic       frame_err;
    logic       busy;

    frame_sequencer #(
        .MAX_LEN (MAX_LEN),
        .TIMEOUT (TIMEOUT)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .demod_bit   (demod_bit),
        .demod_valid (demod_valid),
        .fsc_end     (fsc_end),
        .byte_out    (byte_out),
        .byte_valid  (byte_valid),
        .frame_done  (frame_done),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         len;
        logic [7:0] b0;
        logic [7:0] b1;
        int         gap_at;
        int         gap_len;
        bit         exp_done;
        int         exp_bytes;
    } vec_t;

    vec_t       vecs[10];
    logic [7:0] exp_q[$];
    bit         res_q[$];
    int         n_cmp      = 0;
    int         n_fail     = 0;
    int         cyc        = 0;
    int         bytes_seen = 0;
    int         res_cycle  = -1;
    bit         fsc_pend   = 1'b0;
    bit         fsc_seen   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[15] ^ b;
        return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    // Per-cycle observation at the falling edge; results are popped from the scoreboard queues
    task automatic monitor();
        cyc++;
        if (fsc_pend) begin
            chk("fsc_end_after_result", 32'(fsc_end), 32'd1);
            chk("busy_low_at_fsc", 32'(busy), 32'd0);
            fsc_pend = 1'b0;
            if (fsc_end === 1'b1) fsc_seen = 1'b1;
        end else if (fsc_end !== 1'b0) begin
            chk("fsc_end_unexpected", 32'(fsc_end), 32'd0);
            fsc_seen = 1'b1;
        end
        if (byte_valid === 1'b1) begin
            bytes_seen++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_byte: got byte_out=%02h, required no byte_valid", byte_out);
            end else begin
                chk("byte_out", 32'(byte_out), 32'(exp_q.pop_front()));
            end
        end
        if ((frame_done === 1'b1) || (frame_err === 1'b1)) begin
            chk("done_err_exclusive", 32'(frame_done & frame_err), 32'd0);
            if (res_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_result: got done=%0b err=%0b, required none", frame_done, frame_err);
            end else begin
                chk("frame_result_done", 32'(frame_done), 32'(res_q.pop_front()));
            end
            fsc_pend  = 1'b1;
            res_cycle = cyc;
        end
    endtask

    task automatic step(input logic v, input logic b);
        demod_valid = v;
        demod_bit   = b;
        @(posedge clk);
        @(negedge clk);
        monitor();
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_fsc_end"}, 32'(fsc_end), 32'd0);
        chk({tag, "_byte_out"}, 32'(byte_out), 32'd0);
        chk({tag, "_byte_valid"}, 32'(byte_valid), 32'd0);
        chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        chk({tag, "_frame_err"}, 32'(frame_err), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // Drives one frame; gap_at indexes the bit stream (header bits 0..7, payload after)
    task automatic send_frame(input int len, input logic [7:0] b0, input logic [7:0] b1,
                              input int gap_at, input int gap_len, input bit bad_crc,
                              input bit exp_done, input int exp_bytes);
        logic [7:0]  len8;
        logic [7:0]  data;
        logic [15:0] crc;
        logic        bit_v;
        bit          hdr_ok;
        bit          aborted;
        int          total;
        int          p;
        len8    = 8'(len);
        hdr_ok  = (len >= 1) && (len <= MAX_LEN);
        total   = 8 + (hdr_ok ? len * 8 : 0);
        aborted = 1'b0;
        crc     = 16'hFFFF;
        data    = 8'h00;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("busy_idle", 32'(busy), 32'd0);
        bytes_seen = 0;
        fsc_seen   = 1'b0;
        res_cycle  = -1;
        res_q.push_back(exp_done);
        for (int k = 0; k < total; k++) begin
            if (k == gap_at) begin
                repeat (gap_len) step(1'b0, 1'b0);
                if (gap_len >= TIMEOUT) begin
                    chk("timeout_cycle", 32'(res_cycle), 32'(cyc));
                    aborted = 1'b1;
                    break;
                end
            end
            if (k < 8) begin
                bit_v = len8[3'(k)];
            end else begin
                p = k - 8;
                if (p % 8 == 0) data = (p == 0) ? b0 : (p == 8) ? b1 : 8'($urandom);
                bit_v = data[3'(p % 8)];
                crc   = crc_step(crc, bit_v);
                if (p % 8 == 7) exp_q.push_back(data);
            end
            step(1'b1, bit_v);
            if (k == 0) chk("busy_in_frame", 32'(busy), 32'd1);
        end
        crc[0] = crc[0] ^ bad_crc;
`ifdef FRAME_SEQ_CRC_EN
        if (hdr_ok && !aborted) begin
            for (int i = 0; i < 16; i++) step(1'b1, crc[4'(i)]);
        end
`endif
        for (int c = 0; c < 40 && !fsc_seen; c++) step(!aborted, 1'b0);
        chk("fsc_seen", 32'(fsc_seen), 32'd1);
        step(1'b1, 1'b1);
        chk("no_reentry_without_low", 32'(busy), 32'd0);
        chk("result_consumed", 32'(res_q.size()), 32'd0);
        chk("byte_count", 32'(bytes_seen), 32'(exp_bytes));
        chk("bytes_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [7:0] hdr;
        logic [7:0] data;

        vecs[0] = '{2,   8'hA5, 8'h3C, -1, 0,  1'b1, 2};
        vecs[1] = '{0,   8'h00, 8'h00, -1, 0,  1'b0, 0};
        vecs[2] = '{65,  8'h00, 8'h00, -1, 0,  1'b0, 0};
        vecs[3] = '{64,  8'h11, 8'h22, -1, 0,  1'b1, 64};
        vecs[4] = '{1,   8'h5A, 8'h00, 11, 16, 1'b0, 0};
        vecs[5] = '{3,   8'hC3, 8'h7E, 24, 16, 1'b0, 2};
        vecs[6] = '{2,   8'hF0, 8'h0F, 12, 15, 1'b1, 2};
        vecs[7] = '{200, 8'h00, 8'h00, -1, 0,  1'b0, 0};
        vecs[8] = '{1,   8'h80, 8'h00, 4,  16, 1'b0, 0};
        vecs[9] = '{1,   8'h01, 8'h00, -1, 0,  1'b1, 1};

        rst         = 1'b1;
        demod_valid = 1'b0;
        demod_bit   = 1'b0;
        #2 rst = 1'b0;
        #1 chk_outputs_zero("reset");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        step(1'b0, 1'b0);
        chk_outputs_zero("post_reset");

        for (int v = 0; v < 10; v++) begin
            send_frame(vecs[v].len, vecs[v].b0, vecs[v].b1, vecs[v].gap_at, vecs[v].gap_len,
                       1'b0, vecs[v].exp_done, vecs[v].exp_bytes);
        end

        // Reset in the middle of the second payload byte: no result, no fsc_end
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        bytes_seen = 0;
        hdr = 8'd2;
        for (int i = 0; i < 8; i++) step(1'b1, hdr[3'(i)]);
        data = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) exp_q.push_back(data);
            step(1'b1, data[3'(i)]);
        end
        chk("rst_first_byte_seen", 32'(bytes_seen), 32'd1);
        data = 8'h3C;
        for (int i = 0; i < 3; i++) step(1'b1, data[3'(i)]);
        #2 rst = 1'b0;
        #1 chk_outputs_zero("async_reset");
        repeat (3) step(1'b0, 1'b0);
        rst = 1'b1;
        step(1'b0, 1'b0);
        chk_outputs_zero("after_mid_reset");
        send_frame(2, 8'h3C, 8'hA5, -1, 0, 1'b0, 1'b1, 2);

`ifdef FRAME_SEQ_CRC_EN
        send_frame(1, 8'h31, 8'h00, -1, 0, 1'b0, 1'b1, 1);
        send_frame(1, 8'h31, 8'h00, -1, 0, 1'b1, 1'b0, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
